// File: rtl/seg_digit_scanner.sv
// Time-multiplexed 7-seg digit scanner: per-slot ghost blanking, frame-aligned value updates.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading-zero digits (slot 0 always lit).
module seg_digit_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          scan_en,
    input  logic                          upd_valid,
    output logic                          upd_ready,
    input  logic [NUM_DIGITS*4-1:0]       upd_data,
    output logic [3:0]                    bin_dig,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] dig_idx,
    output logic                          frame_tick
);

    localparam int IDXW = $clog2(NUM_DIGITS);
    localparam int CNTW = $clog2(REFRESH_DIV);
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(REFRESH_DIV - 1);
    localparam logic [CNTW-1:0] BLANK_END = CNTW'(BLANK_CYC);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_DIGITS - 1);

    typedef enum logic {S_BLANK, S_DRIVE} state_t;

    state_t                         state_q, state_d;
    logic [CNTW-1:0]                cnt_q, cnt_d;
    logic [IDXW-1:0]                idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]     disp_q, disp_d;
    logic [NUM_DIGITS-1:0][3:0]     pend_q, pend_d;
    logic                           pend_vld_q, pend_vld_d;
    logic [3:0]                     bin_dig_q, bin_dig_d;
    logic [NUM_DIGITS-1:0]          an_n_q, an_n_d;
    logic                           frame_tick_q, frame_tick_d;
    logic                           slot_end, frame_wrap, accept;
    logic [NUM_DIGITS-1:0]          dark;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            bin_dig_q    <= '0;
            an_n_q       <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            bin_dig_q    <= bin_dig_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Slot timing and blank/drive FSM; everything holds while scan_en is low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        slot_end   = (cnt_q == CNT_LAST);
        frame_wrap = scan_en && slot_end && (idx_q == IDX_LAST);
        if (scan_en) begin
            if (slot_end) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            case (state_q)
                S_BLANK: if (cnt_d == BLANK_END) state_d = S_DRIVE;
                S_DRIVE: if (slot_end) state_d = S_BLANK;
                default: state_d = S_BLANK;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;
    always_comb begin
        dark     = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (disp_q[i] == 4'd0);
            dark[i]  = zero_run;
        end
    end
`else
    assign dark = '0;
`endif

    // Anodes are registered from next-cycle state so an_n lines up with cnt.
    always_comb begin
        an_n_d = '1;
        if (scan_en && state_d == S_DRIVE && !dark[idx_d]) an_n_d[idx_d] = 1'b0;
        bin_dig_d    = disp_q[idx_q];
        frame_tick_d = frame_wrap;
    end

    // Pending buffer: commit only at frame wrap; a same-cycle accept waits a full frame.
    always_comb begin
        accept     = upd_valid && !pend_vld_q;
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (frame_wrap && pend_vld_q) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
        end
        if (accept) begin
            pend_d     = upd_data;
            pend_vld_d = 1'b1;
        end
    end

    assign upd_ready  = !pend_vld_q;
    assign bin_dig    = bin_dig_q;
    assign an_n       = an_n_q;
    assign dig_idx    = idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Scoreboarded bench for seg_digit_scanner at ND=4, REFRESH_DIV=8, BLANK_CYC=2.
module tb_seg_digit_scanner;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        scan_en = 1'b0;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_data = '0;
    logic        upd_ready, frame_tick;
    logic [3:0]  bin_dig;
    logic [3:0]  an_n;
    logic [1:0]  dig_idx;

    int n_cmp = 0;
    int n_bad = 0;

    // timing model and scoreboard of accepted-but-not-yet-displayed values
    int          m_cnt, m_idx;
    bit          m_en, m_tick;
    logic [15:0] m_disp;
    logic [15:0] pend_q[$];

    seg_digit_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BL)) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .upd_valid(upd_valid),
        .upd_ready(upd_ready), .upd_data(upd_data), .bin_dig(bin_dig),
        .an_n(an_n), .dig_idx(dig_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_an();
        logic [3:0] a;
        a = 4'hF;
        if (m_en && m_cnt >= BL) begin
            a[m_idx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (m_idx > 0 && (m_disp >> (4 * m_idx)) == 16'h0) a = 4'hF;
`endif
        end
        return a;
    endfunction

    function automatic logic [3:0] exp_dig();
        logic [15:0] s;
        s = m_disp >> (4 * m_idx);
        return s[3:0];
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_en = 1'b0; m_tick = 1'b0; m_disp = '0;
        pend_q.delete();
    endtask

    // One clock; inputs sampled as the DUT will see them, outputs observed 1ns after.
    task automatic step();
        bit acc, wrap;
        logic [15:0] d;
        acc    = upd_valid && (pend_q.size() == 0);
        d      = upd_data;
        wrap   = scan_en && (m_cnt == RD - 1);
        m_tick = wrap && (m_idx == ND - 1);
        @(posedge clk); #1;
        if (m_tick && pend_q.size() > 0) m_disp = pend_q.pop_front();
        if (acc) pend_q.push_back(d);
        m_en = scan_en;
        if (scan_en) begin
            if (wrap) begin m_cnt = 0; m_idx = (m_idx + 1) % ND; end
            else m_cnt++;
        end
    endtask

    task automatic run_to_tick();
        for (int i = 0; i < 200; i++) begin
            step();
            if (m_tick) break;
        end
    endtask

    task automatic run_to(input int idx, input int cnt);
        for (int i = 0; i < 200; i++) begin
            if (m_idx == idx && m_cnt == cnt) break;
            step();
        end
    endtask

    // Capture one full frame starting at a frame boundary.
    task automatic run_frame(output logic [15:0] seen, output logic [3:0] lit);
        seen = '0; lit = '0;
        for (int i = 0; i < ND * RD; i++) begin
            step();
            if (m_cnt == BL) begin
                seen[4*m_idx +: 4] = bin_dig;
                lit[m_idx] = (an_n[m_idx] == 1'b0);
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        scan_en = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        n_cmp++; if (an_n !== 4'hF) begin n_bad++; $display("FAIL reset_an_n: got %b want 1111", an_n); end
        n_cmp++; if (bin_dig !== 4'h0) begin n_bad++; $display("FAIL reset_bin_dig: got %h want 0", bin_dig); end
        n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", upd_ready); end
        n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
        n_cmp++; if (dig_idx !== 2'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", dig_idx); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int ticks;
        ticks = 0;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (frame_tick === 1'b1) ticks++;
            n_cmp++; if (an_n !== exp_an()) begin n_bad++; $display("FAIL scan_an_n edge %0d: got %b want %b", k, an_n, exp_an()); end
            n_cmp++; if (dig_idx !== 2'(m_idx)) begin n_bad++; $display("FAIL scan_idx edge %0d: got %0d want %0d", k, dig_idx, m_idx); end
            n_cmp++; if (frame_tick !== m_tick) begin n_bad++; $display("FAIL scan_tick edge %0d: got %b want %b", k, frame_tick, m_tick); end
        end
        n_cmp++; if (ticks != 2) begin n_bad++; $display("FAIL scan_tick_count: got %0d want 2", ticks); end
    endtask

    task automatic test_update();
        logic [15:0] seen;
        logic [3:0]  lit;
        run_to(1, 4);
        upd_data = 16'h1234; upd_valid = 1'b1;
        step();
        upd_valid = 1'b0; upd_data = 16'hFFFF;
        n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL upd_ready_drop: got %b want 0", upd_ready); end
        for (int i = 0; i < 64 && !m_tick; i++) begin
            step();
            if (m_cnt >= BL && !m_tick) begin
                n_cmp++; if (bin_dig !== exp_dig()) begin n_bad++; $display("FAIL upd_old_value: got %h want %h", bin_dig, exp_dig()); end
            end
        end
        n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL upd_ready_rise: got %b want 1", upd_ready); end
        run_frame(seen, lit);
        n_cmp++; if (seen !== 16'h1234) begin n_bad++; $display("FAIL upd_frame_digits: got %h want 1234", seen); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seen;
        logic [3:0]  lit;
        int held;
        bit acc;
        run_to(0, 3);
        upd_data = 16'hAAAA; upd_valid = 1'b1;
        step();
        upd_data = 16'hBCDE; held = 0; acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = (pend_q.size() == 0);
            n_cmp++; if (upd_ready !== acc) begin n_bad++; $display("FAIL b2b_ready: got %b want %b", upd_ready, acc); end
            step();
            if (!acc) held++;
        end
        upd_valid = 1'b0;
        // held from slot0 cnt4 through the wrap edge: 28 remaining edges of the frame
        n_cmp++; if (held != 28) begin n_bad++; $display("FAIL b2b_hold_cycles: got %0d want 28", held); end
        run_to(0, 7);
        run_to_tick();
        run_frame(seen, lit);
        n_cmp++; if (seen !== 16'hBCDE) begin n_bad++; $display("FAIL b2b_second_value: got %h want bcde", seen); end
    endtask

    task automatic test_wrap_accept();
        logic [15:0] seen;
        logic [3:0]  lit;
        run_to(ND - 1, RD - 1);
        upd_data = 16'h5678; upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL wrap_accept_ready: got %b want 0", upd_ready); end
        run_frame(seen, lit);
        n_cmp++; if (seen !== 16'hBCDE) begin n_bad++; $display("FAIL wrap_no_bypass: got %h want bcde", seen); end
        run_frame(seen, lit);
        n_cmp++; if (seen !== 16'h5678) begin n_bad++; $display("FAIL wrap_next_frame: got %h want 5678", seen); end
    endtask

    task automatic test_scan_en();
        int edges;
        run_to(2, 4);
        scan_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            upd_data = 16'h0050; upd_valid = (i == 5);
            step();
            n_cmp++; if (an_n !== 4'hF) begin n_bad++; $display("FAIL freeze_an_n: got %b want 1111", an_n); end
            n_cmp++; if (dig_idx !== 2'd2) begin n_bad++; $display("FAIL freeze_idx: got %0d want 2", dig_idx); end
            n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL freeze_tick: got %b want 0", frame_tick); end
        end
        upd_valid = 1'b0;
        n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL freeze_accept: got %b want 0", upd_ready); end
        scan_en = 1'b1;
        step();
        n_cmp++; if (an_n !== 4'b1011) begin n_bad++; $display("FAIL resume_an_n: got %b want 1011", an_n); end
        edges = 1;
        for (int i = 0; i < 20 && dig_idx == 2'd2; i++) begin step(); edges++; end
        n_cmp++; if (edges != 4) begin n_bad++; $display("FAIL resume_slot_len: got %0d want 4", edges); end
        n_cmp++; if (an_n !== 4'hF) begin n_bad++; $display("FAIL idx_change_blank: got %b want 1111", an_n); end
    endtask

    task automatic test_leading_zero();
        logic [15:0] seen;
        logic [3:0]  lit, want;
        run_to_tick();
        run_frame(seen, lit);
`ifdef LEADING_ZERO_BLANK_EN
        want = 4'b0011;
`else
        want = 4'b1111;
`endif
        n_cmp++; if (seen !== 16'h0050) begin n_bad++; $display("FAIL lz_digits: got %h want 0050", seen); end
        n_cmp++; if (lit !== want) begin n_bad++; $display("FAIL lz_lit_0050: got %b want %b", lit, want); end
        run_to(1, 0);
        upd_data = 16'h0000; upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        run_to_tick();
        run_frame(seen, lit);
`ifdef LEADING_ZERO_BLANK_EN
        want = 4'b0001;
`else
        want = 4'b1111;
`endif
        n_cmp++; if (lit !== want) begin n_bad++; $display("FAIL lz_lit_0000: got %b want %b", lit, want); end
    endtask

    task automatic test_async_reset();
        logic [15:0] seen;
        logic [3:0]  lit;
        run_to(0, 3);
        upd_data = 16'h7777; upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        run_to(1, 4);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (an_n !== 4'hF) begin n_bad++; $display("FAIL async_an_n: got %b want 1111", an_n); end
        n_cmp++; if (dig_idx !== 2'd0) begin n_bad++; $display("FAIL async_idx: got %0d want 0", dig_idx); end
        n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL async_ready: got %b want 1", upd_ready); end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_to_tick();
        run_frame(seen, lit);
        n_cmp++; if (seen !== 16'h0000) begin n_bad++; $display("FAIL async_pending_lost: got %h want 0000", seen); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_update();
        test_back_to_back();
        test_wrap_accept();
        test_scan_en();
        test_leading_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
